// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, the multiply FSM state encoding,
// and small decode helpers. The instruction decoder uses these as well.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_MULT  = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00011;
  localparam logic [4:0] OP_OR    = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_NOR   = 5'b00110;
  localparam logic [4:0] OP_SLL   = 5'b00111;
  localparam logic [4:0] OP_SRL   = 5'b01000;
  localparam logic [4:0] OP_ROTR  = 5'b01001;
  localparam logic [4:0] OP_SRA   = 5'b01010;
  localparam logic [4:0] OP_SEH   = 5'b01011;
  localparam logic [4:0] OP_ADDU  = 5'b01100;
  localparam logic [4:0] OP_MULTU = 5'b01101;
  localparam logic [4:0] OP_SLT   = 5'b01110;
  localparam logic [4:0] OP_SEB   = 5'b01111;
  localparam logic [4:0] OP_SLTU  = 5'b10000;
  localparam logic [4:0] OP_SLLV  = 5'b10001;
  localparam logic [4:0] OP_SRLV  = 5'b10010;
  localparam logic [4:0] OP_SRAV  = 5'b10011;
  localparam logic [4:0] OP_ROTRV = 5'b10100;
  localparam logic [4:0] OP_PASS  = 5'b10101;
  localparam logic [4:0] OP_LUI   = 5'b10110;
  localparam logic [4:0] OP_BLTZ  = 5'b10111;
  localparam logic [4:0] OP_BLEZ  = 5'b11000;
  localparam logic [4:0] OP_BGTZ  = 5'b11001;
  localparam logic [4:0] OP_BGEZ  = 5'b11010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2
  } alu_state_e;

  function automatic logic is_mult(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_signed_mult(input logic [4:0] op);
    return op == OP_MULT;
  endfunction

endpackage

// File: rtl/multi_cycle_alu_if.sv
// Request/response bundle between the issue stage and the multi-cycle ALU,
// plus the HI/LO view and the FSM state for observation.
interface multi_cycle_alu_if;
  import alu_pkg::*;

  // Handshake: Start is a single-cycle request taken on a rising edge only
  // while Busy is low (otherwise dropped); Done is a one-cycle pulse during
  // which Result and Zero are valid. Result/Zero hold between pulses.
  logic              Start;
  logic [4:0]        ALUOp;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [4:0]        Shamt;
  logic              HiWrite;
  logic              LoWrite;
  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] Result;
  logic              Zero;
  logic [DATA_W-1:0] Hi;
  logic [DATA_W-1:0] Lo;
  alu_state_e        State;

  modport master (
    output Start, ALUOp, A, B, Shamt, HiWrite, LoWrite,
    input  Busy, Done, Result, Zero, Hi, Lo, State
  );

  modport slave (
    input  Start, ALUOp, A, B, Shamt, HiWrite, LoWrite,
    output Busy, Done, Result, Zero, Hi, Lo, State
  );

endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative 32x32 multiplier: one shift-add step per cycle on operand
// magnitudes, then a sign fix-up cycle; done pulses with the final product.
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(W);

  alu_state_e     phase_q, phase_d;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   mcand_q;
  logic           neg_q;
  logic [CW-1:0]  cnt_q;
  logic           done_q;

  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [W:0]     sum;

  // Negating -2^31 yields 0x80000000, which is the correct unsigned magnitude.
  assign mag_a = (is_signed && a[W-1]) ? -a : a;
  assign mag_b = (is_signed && b[W-1]) ? -b : b;
  assign sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q};

  always_comb begin
    phase_d = phase_q;
    if (start) begin
      phase_d = ST_MUL;
    end else begin
      case (phase_q)
        ST_MUL:  if (cnt_q == CW'(W - 1)) phase_d = ST_FIX;
        ST_FIX:  phase_d = ST_IDLE;
        default: phase_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= ST_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      done_q  <= 1'b0;
      if (start) begin
        // Multiplier magnitude sits in the low half and shifts out bit by bit.
        acc_q   <= {{W{1'b0}}, mag_b};
        mcand_q <= mag_a;
        neg_q   <= is_signed && (a[W-1] ^ b[W-1]);
        cnt_q   <= '0;
      end else if (phase_q == ST_MUL) begin
        acc_q <= acc_q[0] ? {sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
        cnt_q <= cnt_q + CW'(1);
      end else if (phase_q == ST_FIX) begin
        if (neg_q) acc_q <= -acc_q;
        done_q <= 1'b1;
      end
    end
  end

  assign product = acc_q;
  assign done    = done_q;

endmodule

// File: rtl/multi_cycle_alu.sv
// Multi-cycle ALU: single-cycle combinational ops behind one Result register,
// and an iterative multiply that writes HI/LO when it completes.
module multi_cycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  multi_cycle_alu_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  alu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic               go_q;
  logic [4:0]         op_q;
  logic [4:0]         shamt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               hiw_q;
  logic               low_q;

  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   alu_result;
  logic               alu_zero;
  logic [2*WIDTH-1:0] rot_imm;
  logic [2*WIDTH-1:0] rot_var;
  logic               a_neg;
  logic               a_is_zero;

  assign accept    = bus.Start && (state_q == ST_IDLE);
  assign mul_start = accept && is_mult(bus.ALUOp);

  shift_add_multiplier #(.W(WIDTH)) u_mul (
    .clk       (Clk),
    .rst       (Rst),
    .start     (mul_start),
    .is_signed (is_signed_mult(bus.ALUOp)),
    .a         (bus.A),
    .b         (bus.B),
    .product   (mul_product),
    .done      (mul_done)
  );

  // FIX lasts until the multiplier presents its sign-corrected product.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  if (mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == ST_MUL) ? cnt_q + CNT_W'(1) : '0;
    end
  end

  // Operand capture for the single-cycle path; evaluated on the next edge.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      go_q    <= 1'b0;
      op_q    <= '0;
      shamt_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hiw_q   <= 1'b0;
      low_q   <= 1'b0;
    end else begin
      go_q <= accept && !is_mult(bus.ALUOp);
      if (accept) begin
        op_q    <= bus.ALUOp;
        shamt_q <= bus.Shamt;
        a_q     <= bus.A;
        b_q     <= bus.B;
        hiw_q   <= bus.HiWrite;
        low_q   <= bus.LoWrite;
      end
    end
  end

  assign rot_imm   = {b_q, b_q} >> shamt_q;
  assign rot_var   = {b_q, b_q} >> a_q[4:0];
  assign a_neg     = a_q[WIDTH-1];
  assign a_is_zero = (a_q == '0);

  always_comb begin
    alu_result = '0;
    case (op_q)
      OP_ADD, OP_ADDU: alu_result = a_q + b_q;
      OP_SUB:          alu_result = a_q - b_q;
      OP_AND:          alu_result = a_q & b_q;
      OP_OR:           alu_result = a_q | b_q;
      OP_XOR:          alu_result = a_q ^ b_q;
      OP_NOR:          alu_result = ~(a_q | b_q);
      OP_SLL:          alu_result = b_q << shamt_q;
      OP_SRL:          alu_result = b_q >> shamt_q;
      OP_ROTR:         alu_result = rot_imm[WIDTH-1:0];
      OP_SRA:          alu_result = $signed(b_q) >>> shamt_q;
      OP_SLLV:         alu_result = b_q << a_q[4:0];
      OP_SRLV:         alu_result = b_q >> a_q[4:0];
      OP_SRAV:         alu_result = $signed(b_q) >>> a_q[4:0];
      OP_ROTRV:        alu_result = rot_var[WIDTH-1:0];
      OP_SEH:          alu_result = {{(WIDTH-16){b_q[15]}}, b_q[15:0]};
      OP_SEB:          alu_result = {{(WIDTH-8){b_q[7]}}, b_q[7:0]};
      OP_LUI:          alu_result = {b_q[WIDTH-17:0], 16'h0000};
      OP_PASS:         alu_result = a_q;
      OP_SLT:          alu_result = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU:         alu_result = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      default:         alu_result = '0;
    endcase

    // Zero doubles as the branch-taken flag; for sub it means A == B.
    alu_zero = (alu_result == '0);
    case (op_q)
      OP_BLTZ: alu_zero = a_neg;
      OP_BLEZ: alu_zero = a_neg || a_is_zero;
      OP_BGTZ: alu_zero = !a_neg && !a_is_zero;
      OP_BGEZ: alu_zero = !a_neg;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (go_q) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
        done_q   <= 1'b1;
        if (op_q == OP_PASS && hiw_q) hi_q <= a_q;
        if (op_q == OP_PASS && low_q) lo_q <= a_q;
      end else if (state_q == ST_FIX && mul_done) begin
        result_q <= mul_product[WIDTH-1:0];
        zero_q   <= (mul_product[WIDTH-1:0] == '0);
        done_q   <= 1'b1;
        hi_q     <= mul_product[2*WIDTH-1:WIDTH];
        lo_q     <= mul_product[WIDTH-1:0];
      end
    end
  end

  assign bus.Busy   = (state_q != ST_IDLE);
  assign bus.Done   = done_q;
  assign bus.Result = result_q;
  assign bus.Zero   = zero_q;
  assign bus.Hi     = hi_q;
  assign bus.Lo     = lo_q;
  assign bus.State  = state_q;

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Directed and randomized checks of multi_cycle_alu against a scoreboard
// fed by an independent reference model.
module tb_multi_cycle_alu;
  import alu_pkg::*;

  localparam int W = 32;

  // Clock / reset
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  multi_cycle_alu_if bus ();

  multi_cycle_alu #(.WIDTH(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_z_q[$];
  logic [W-1:0] exp_hi_q[$];
  logic [W-1:0] exp_lo_q[$];
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {zero, result}
  function automatic logic [W:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] sh);
    logic [W-1:0] r;
    logic         z;
    r = '0;
    case (op)
      5'b00000, 5'b01100: r = a + b;
      5'b00001: r = a - b;
      5'b00011: r = a & b;
      5'b00100: r = a | b;
      5'b00101: r = a ^ b;
      5'b00110: r = ~(a | b);
      5'b00111: r = b << sh;
      5'b01000: r = b >> sh;
      5'b01001: begin r = b; repeat (sh) r = {r[0], r[W-1:1]}; end
      5'b01010: begin r = b; repeat (sh) r = {r[W-1], r[W-1:1]}; end
      5'b10001: r = b << a[4:0];
      5'b10010: r = b >> a[4:0];
      5'b10011: begin r = b; repeat (a[4:0]) r = {r[W-1], r[W-1:1]}; end
      5'b10100: begin r = b; repeat (a[4:0]) r = {r[0], r[W-1:1]}; end
      5'b01011: r = {{16{b[15]}}, b[15:0]};
      5'b01111: r = {{24{b[7]}}, b[7:0]};
      5'b10110: r = b << 16;
      5'b10101: r = a;
      5'b01110: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      5'b10000: r = (a < b) ? 32'd1 : 32'd0;
      default:  r = '0;
    endcase
    z = (r == 0);
    case (op)
      5'b10111: z = (int'(a) <  0);
      5'b11000: z = (int'(a) <= 0);
      5'b11001: z = (int'(a) >  0);
      5'b11010: z = (int'(a) >= 0);
      default: ;
    endcase
    return {z, r};
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'(int'(a));
      sb = longint'(int'(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    return 64'(sa * sb);
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh, input logic hw, input logic lw);
    logic [W:0]     rz;
    logic [2*W-1:0] p;
    if (op == OP_MULT || op == OP_MULTU) begin
      p    = ref_mul(op == OP_MULT, a, b);
      hi_m = p[2*W-1:W];
      lo_m = p[W-1:0];
      exp_q.push_back(p[W-1:0]);
      exp_z_q.push_back(p[W-1:0] == 0);
    end else begin
      rz = ref_alu(op, a, b, sh);
      if (op == 5'b10101 && hw) hi_m = a;
      if (op == 5'b10101 && lw) lo_m = a;
      exp_q.push_back(rz[W-1:0]);
      exp_z_q.push_back(rz[W]);
    end
    exp_hi_q.push_back(hi_m);
    exp_lo_q.push_back(lo_m);
    bus.Start = 1'b1; bus.ALUOp = op; bus.A = a; bus.B = b;
    bus.Shamt = sh; bus.HiWrite = hw; bus.LoWrite = lw;
    step();
    bus.Start = 1'b0; bus.HiWrite = 1'b0; bus.LoWrite = 1'b0;
  endtask

  // Scoreboard: wait for Done, pop and compare, then confirm a single pulse.
  task automatic wait_done(input string tag, input int budget, input int inject_at,
                           output int lat, output int busy_n, output alu_state_e st_first);
    logic [W-1:0] er;
    lat = 0; busy_n = 0; st_first = bus.State;
    while (bus.Done !== 1'b1 && lat < budget) begin
      if (bus.Busy === 1'b1) busy_n++;
      if (lat == inject_at) begin
        bus.Start = 1'b1; bus.ALUOp = OP_ADD; bus.A = 32'h1; bus.B = 32'h1;
      end
      step();
      bus.Start = 1'b0;
      lat++;
    end
    n_checks++;
    assert (bus.Done === 1'b1) else begin
      n_fail++;
      $error("FAIL %s_timeout: Done %b after %0d cycles, required 1", tag, bus.Done, budget);
    end
    if (bus.Done === 1'b1 && exp_q.size() > 0) begin
      er = exp_q.pop_front();
      check({tag, "_result"}, bus.Result, er);
      check({tag, "_zero"}, 32'(bus.Zero), 32'(exp_z_q.pop_front()));
      check({tag, "_hi"}, bus.Hi, exp_hi_q.pop_front());
      check({tag, "_lo"}, bus.Lo, exp_lo_q.pop_front());
      step();
      check({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
      check({tag, "_hold"}, bus.Result, er);
    end
  endtask

  initial begin
    int         lat, busy_n, done_n;
    alu_state_e st;
    logic [4:0] op;

    bus.Start = 1'b0; bus.ALUOp = '0; bus.A = '0; bus.B = '0;
    bus.Shamt = '0; bus.HiWrite = 1'b0; bus.LoWrite = 1'b0;
    Rst = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_result", bus.Result, 32'd0);
    check("rst_zero", 32'(bus.Zero), 32'd0);
    check("rst_hi", bus.Hi, 32'd0);
    check("rst_lo", bus.Lo, 32'd0);
    check("rst_state", 32'(bus.State), 32'(ST_IDLE));
    Rst = 1'b1;
    step();

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0, 1'b0);
    wait_done("add_ovf", 10, -1, lat, busy_n, st);
    check("add_latency", 32'(lat), 32'd1);
    check("add_const", bus.Result, 32'h8000_0000);

    issue(OP_SUB, 32'd5, 32'd5, 5'd0, 1'b0, 1'b0);
    wait_done("sub_eq", 10, -1, lat, busy_n, st);
    issue(OP_SUB, 32'd5, 32'd6, 5'd0, 1'b0, 1'b0);
    wait_done("sub_ne", 10, -1, lat, busy_n, st);
    issue(OP_ROTR, 32'h0, 32'h1, 5'd1, 1'b0, 1'b0);
    wait_done("rotr", 10, -1, lat, busy_n, st);
    check("rotr_const", bus.Result, 32'h8000_0000);
    issue(OP_SRAV, 32'd4, 32'hF000_0000, 5'd0, 1'b0, 1'b0);
    wait_done("srav", 10, -1, lat, busy_n, st);
    check("srav_const", bus.Result, 32'hFF00_0000);

    issue(OP_PASS, 32'hAAAA_0001, 32'h0, 5'd0, 1'b1, 1'b0);
    wait_done("mthi", 10, -1, lat, busy_n, st);
    issue(OP_PASS, 32'h5555_0002, 32'h0, 5'd0, 1'b1, 1'b1);
    wait_done("mthilo", 10, -1, lat, busy_n, st);
    issue(OP_ADD, 32'h1234_5678, 32'h1, 5'd0, 1'b1, 1'b1);
    wait_done("hilo_ignored", 10, -1, lat, busy_n, st);
    check("hilo_ignored_hi", bus.Hi, 32'h5555_0002);

    issue(OP_BLEZ, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    wait_done("blez0", 10, -1, lat, busy_n, st);
    issue(OP_BGTZ, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    wait_done("bgtz0", 10, -1, lat, busy_n, st);
    issue(5'b11111, 32'h9, 32'h9, 5'd0, 1'b1, 1'b1);
    wait_done("illegal", 10, -1, lat, busy_n, st);
    check("illegal_latency", 32'(lat), 32'd1);

    for (int i = 0; i < 24; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == OP_MULT || op == OP_MULTU) op = OP_XOR;
      issue(op, $urandom(), $urandom(), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done("rand", 10, -1, lat, busy_n, st);
    end

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b0, 1'b0);
    wait_done("mult_neg", 60, 5, lat, busy_n, st);
    check("mult_latency", 32'(lat), 32'd34);
    check("mult_busy_cycles", 32'(busy_n), 32'd34);
    check("mult_state", 32'(st), 32'(ST_MUL));
    check("mult_hi_const", bus.Hi, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.Lo, 32'hFFFF_FFEB);
    done_n = 0;
    repeat (5) begin
      step();
      if (bus.Done === 1'b1) done_n++;
    end
    check("mult_single_done", 32'(done_n), 32'd0);
    check("mult_ignored_start", bus.Result, 32'hFFFF_FFEB);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b0, 1'b0);
    wait_done("multu", 60, -1, lat, busy_n, st);
    check("multu_hi_const", bus.Hi, 32'h1);
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 5'd0, 1'b0, 1'b0);
    wait_done("mult_min", 60, -1, lat, busy_n, st);
    check("mult_min_hi_const", bus.Hi, 32'h4000_0000);
    issue(OP_MULT, $urandom(), $urandom(), 5'd0, 1'b0, 1'b0);
    wait_done("mult_rand", 60, -1, lat, busy_n, st);
    issue(OP_MULTU, $urandom(), $urandom(), 5'd0, 1'b0, 1'b0);
    wait_done("multu_rand", 60, -1, lat, busy_n, st);

    // Abort a multiply with reset, then issue on the first cycle after release
    issue(OP_MULT, 32'h0001_2345, 32'h0000_0777, 5'd0, 1'b0, 1'b0);
    repeat (9) step();
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    exp_q.delete(); exp_z_q.delete(); exp_hi_q.delete(); exp_lo_q.delete();
    hi_m = '0; lo_m = '0;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_hi", bus.Hi, 32'd0);
    check("abort_lo", bus.Lo, 32'd0);
    issue(OP_ADD, 32'd20, 32'd22, 5'd0, 1'b0, 1'b0);
    wait_done("post_abort_add", 10, -1, lat, busy_n, st);
    check("post_abort_latency", 32'(lat), 32'd1);
    done_n = 0;
    repeat (40) begin
      step();
      if (bus.Done === 1'b1) done_n++;
    end
    check("abort_no_late_done", 32'(done_n), 32'd0);
    check("abort_hi_late", bus.Hi, 32'd0);
    check("abort_lo_late", bus.Lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_alu.md
MULTI_CYCLE_ALU -- requirements
Module: multi_cycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port Start  input  1  one-cycle request, accepted only when Busy=0.
REQ-005 SHALL have port ALUOp  input  5  operation code, sampled with Start.
REQ-006 SHALL have ports A, B  input  32 each  operands, sampled with Start.
REQ-007 SHALL have port Shamt  input  5  immediate shift amount, sampled with Start.
REQ-008 SHALL have ports HiWrite, LoWrite  input  1 each  with ALUOp=10101 and Start, load A into HI or LO.
REQ-009 SHALL have port Busy  output  1  high from the cycle after an accepted multiply until Done.
REQ-010 SHALL have port Done  output  1  one-cycle pulse; Result and Zero valid while high.
REQ-011 SHALL have ports Result  output  32, and Zero  output  1  (Result==0, or branch condition true).
REQ-012 SHALL have ports Hi, Lo  output  32 each  current HI/LO register contents.

Function
REQ-013 SHALL implement: 00000 add, 00001 sub, 00011 and, 00100 or, 00101 xor, 00110 nor, 01100 addu; arithmetic is mod 2^32, no overflow trap.
REQ-014 SHALL implement shifts: 00111 sll, 01000 srl, 01001 rotr, 01010 sra on B by Shamt; 10001 sllv, 10010 srlv, 10011 srav, 10100 rotrv on B by A[4:0].
REQ-015 SHALL implement 01011 seh (sign-extend B[15:0]), 01111 seb (sign-extend B[7:0]), 10110 lui (B<<16), 10101 pass-through (Result=A).
REQ-016 SHALL implement 01110 slt (signed) and 10000 sltu (unsigned), Result = 0 or 1.
REQ-017 SHALL implement branch compares on A: 10111 A<0, 11000 A<=0, 11001 A>0, 11010 A>=0; Zero=1 when true, Result=0.
REQ-018 For 00001, Zero SHALL reflect A==B so beq/bne resolve from Zero.
REQ-019 Codes 11011-11111 SHALL give Result=0, Zero=1, Done after 1 cycle, no HI/LO change.
REQ-020 Non-multiply ops SHALL complete with latency 1: Start sampled at edge N, Done=1 and Result valid after edge N+1.
REQ-021 00010 (signed) and 01101 (unsigned) SHALL multiply iteratively: 64-bit product, Result = product[31:0].
REQ-022 Multiply FSM SHALL be IDLE -> MUL (32 cycles, one shift-add per cycle on operand magnitudes) -> FIX (negate if signed and signs differ) -> IDLE with Done; Done appears 34 cycles after the Start edge.
REQ-023 On multiply completion SHALL write HI=product[63:32], LO=product[31:0] on the same edge Done rises.
REQ-024 Start while Busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-025 Signed multiply SHALL be exact for -2^31 operands, e.g. 0x80000000*0x80000000 gives HI=0x40000000, LO=0.
REQ-026 Done SHALL be low in every cycle without a completion; Result and Zero hold their last value between completions.
REQ-027 HiWrite and LoWrite together SHALL load both registers; either alone with any other ALUOp SHALL be ignored.

Reset
REQ-028 While Rst=0 at an edge, SHALL set FSM=IDLE, Busy=0, Done=0, Result=0, Zero=0, HI=0, LO=0.
REQ-029 Reset mid-multiply SHALL abort the operation with no HI/LO write, and a Start in the first cycle after release SHALL be accepted.

Structure
REQ-030 ALUOp code constants and the FSM state encoding SHALL live in shared package alu_pkg, also used by the instruction decoder.
REQ-031 The iterative multiplier datapath SHALL be sub-module shift_add_multiplier (start, signed flag, operands in; 64-bit product and done out).
REQ-032 Shifts, logic, extension and compares SHALL be combinational ahead of a single Result register.

Verification
REQ-033 add 0x7FFFFFFF+1 -> Result=0x80000000, Done one cycle later, Zero=0.
REQ-034 sub A=B=5 -> Zero=1; rotr B=0x00000001, Shamt=1 -> 0x80000000; srav A=4, B=0xF0000000 -> 0xFF000000.
REQ-035 mult -3*7 -> Busy for 34 cycles, Done on cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB; multu 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
REQ-036 Start add during a multiply -> ignored; multiply result is unchanged; a single Done pulse.
REQ-037 Rst=0 at cycle 10 of a multiply -> HI/LO stay 0, Busy=0 next cycle, and a following add completes normally.
REQ-038 blez A=0 -> Zero=1; bgtz A=0 -> Zero=0; ALUOp 11111 -> Result=0, Zero=1.
